// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I decode/issue stage with operand forwarding and ID/EX register
module alu_issue_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic                  fwd_valid,
    input  logic [REG_ADDR_W-1:0] fwd_rd,
    input  logic [XLEN-1:0]       fwd_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_a,
    output logic [XLEN-1:0]       out_b,
    output logic [2:0]            out_alu_control,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic [XLEN-1:0]       out_store_data,
    output logic                  out_branch,
    output logic                  out_branch_ne,
    output logic                  out_illegal
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SRA = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction fields
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rd_idx;
    logic [REG_ADDR_W-1:0] rs1_idx;
    logic [REG_ADDR_W-1:0] rs2_idx;
    logic [XLEN-1:0]       imm_i;
    logic [XLEN-1:0]       imm_s;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic [XLEN-1:0]       shamt_r;
    logic [XLEN-1:0]       shamt_i;

    assign opcode  = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign funct7  = in_instr[31:25];
    assign rd_idx  = REG_ADDR_W'(in_instr[11:7]);
    assign rs1_idx = REG_ADDR_W'(in_instr[19:15]);
    assign rs2_idx = REG_ADDR_W'(in_instr[24:20]);
    assign imm_i   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s   = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};

    // Operand select: x0 reads zero, else a matching EX/MEM result overrides the register file
    always_comb begin
        rs1_val = in_rs1_data;
        rs2_val = in_rs2_data;
        if (rs1_idx == '0) begin
            rs1_val = '0;
        end else if (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs1_idx)) begin
            rs1_val = fwd_data;
        end
        if (rs2_idx == '0) begin
            rs2_val = '0;
        end else if (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs2_idx)) begin
            rs2_val = fwd_data;
        end
    end

    // The ALU shifts by the whole b operand, so shift amounts are zero-extended from 5 bits
    assign shamt_r = {{(XLEN-5){1'b0}}, rs2_val[4:0]};
    assign shamt_i = {{(XLEN-5){1'b0}}, in_instr[24:20]};

    logic [2:0]      alu_d;
    logic [XLEN-1:0] a_d;
    logic [XLEN-1:0] b_d;
    logic            reg_write_d;
    logic            mem_read_d;
    logic            mem_write_d;
    logic            branch_d;
    logic            branch_ne_d;
    logic            illegal_d;

    // Decode opcode/funct into ALU operation, operands and pipeline control bits
    always_comb begin
        alu_d       = ALU_ADD;
        a_d         = rs1_val;
        b_d         = rs2_val;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        branch_d    = 1'b0;
        branch_ne_d = 1'b0;
        illegal_d   = 1'b0;
        case (opcode)
            OP_R: begin
                reg_write_d = 1'b1;
                case ({funct7, funct3})
                    {F7_ZERO, 3'b000}: alu_d = ALU_ADD;
                    {F7_ALT,  3'b000}: alu_d = ALU_SUB;
                    {F7_ZERO, 3'b001}: begin alu_d = ALU_SLL; b_d = shamt_r; end
                    {F7_ZERO, 3'b100}: alu_d = ALU_XOR;
                    {F7_ZERO, 3'b101}: begin alu_d = ALU_SRL; b_d = shamt_r; end
                    {F7_ALT,  3'b101}: begin alu_d = ALU_SRA; b_d = shamt_r; end
                    {F7_ZERO, 3'b111}: alu_d = ALU_AND;
                    default:           illegal_d = 1'b1;
                endcase
            end
            OP_I: begin
                reg_write_d = 1'b1;
                b_d         = imm_i;
                case (funct3)
                    3'b000: alu_d = ALU_ADD;
                    3'b100: alu_d = ALU_XOR;
                    3'b111: alu_d = ALU_AND;
                    3'b001: begin
                        b_d = shamt_i;
                        if (funct7 == F7_ZERO) alu_d = ALU_SLL;
                        else                   illegal_d = 1'b1;
                    end
                    3'b101: begin
                        b_d = shamt_i;
                        if (funct7 == F7_ZERO)     alu_d = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_d = ALU_SRA;
                        else                       illegal_d = 1'b1;
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            OP_LOAD: begin
                reg_write_d = 1'b1;
                mem_read_d  = 1'b1;
                b_d         = imm_i;
            end
            OP_STORE: begin
                mem_write_d = 1'b1;
                b_d         = imm_s;
            end
            OP_BRANCH: begin
                alu_d    = ALU_SUB;
                branch_d = 1'b1;
                case (funct3)
                    3'b000:  branch_ne_d = 1'b0;
                    3'b001:  branch_ne_d = 1'b1;
                    default: illegal_d   = 1'b1;
                endcase
            end
            default: illegal_d = 1'b1;
        endcase
        if (illegal_d) begin
            alu_d       = ALU_ADD;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            branch_d    = 1'b0;
            branch_ne_d = 1'b0;
        end
        if (rd_idx == '0) begin
            reg_write_d = 1'b0;
        end
    end

    logic                  valid_q;
    logic [XLEN-1:0]       a_q;
    logic [XLEN-1:0]       b_q;
    logic [2:0]            alu_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  reg_write_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [XLEN-1:0]       store_data_q;
    logic                  branch_q;
    logic                  branch_ne_q;
    logic                  illegal_q;
    logic                  transfer;

    assign in_ready = !valid_q || out_ready;
    assign transfer = in_valid && in_ready;

    // ID/EX register: reset > flush > capture on transfer > drain; payload moves only on transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            alu_q        <= ALU_ADD;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            store_data_q <= '0;
            branch_q     <= 1'b0;
            branch_ne_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (transfer) begin
            valid_q      <= 1'b1;
            a_q          <= a_d;
            b_q          <= b_d;
            alu_q        <= alu_d;
            rd_q         <= rd_idx;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            store_data_q <= rs2_val;
            branch_q     <= branch_d;
            branch_ne_q  <= branch_ne_d;
            illegal_q    <= illegal_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid       = valid_q;
    assign out_a           = a_q;
    assign out_b           = b_q;
    assign out_alu_control = alu_q;
    assign out_rd          = rd_q;
    assign out_reg_write   = reg_write_q;
    assign out_mem_read    = mem_read_q;
    assign out_mem_write   = mem_write_q;
    assign out_store_data  = store_data_q;
    assign out_branch      = branch_q;
    assign out_branch_ne   = branch_ne_q;
    assign out_illegal     = illegal_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue stage that feeds the ALU. It accepts RV32I instruction words with operand values over a valid/ready handshake and decodes the ALU operation. It selects and forwards operands, then registers alu_control, a and b into a single ID/EX pipeline register with flush and stall support. Its outputs drive the ALU's a, b and alu_control inputs directly, plus the control bits the EX/MEM stages need.

Parameters:
XLEN, 32, operand/data width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  instruction + operands valid
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction word
in_rs1_data  in  XLEN  register-file value of rs1
in_rs2_data  in  XLEN  register-file value of rs2
fwd_valid  in  1  EX/MEM writeback candidate valid
fwd_rd  in  REG_ADDR_W  destination of forwarded value
fwd_data  in  XLEN  forwarded value
flush  in  1  discard current and incoming instruction
out_valid  out  1  ID/EX register holds an instruction
out_ready  in  1  EX stage accepts this cycle
out_a  out  XLEN  ALU operand a
out_b  out  XLEN  ALU operand b
out_alu_control  out  3  ALU operation select
out_rd  out  REG_ADDR_W  destination register
out_reg_write  out  1  write rd at writeback
out_mem_read  out  1  load
out_mem_write  out  1  store
out_store_data  out  XLEN  rs2 value for stores
out_branch  out  1  conditional branch (beq/bne)
out_branch_ne  out  1  1 = bne, 0 = beq
out_illegal  out  1  opcode/funct not supported

Behaviour:
- ALU encoding: 000 add, 001 sub, 010 sra, 011 sll, 100 srl, 101 and, 110 xor.
- Decode by opcode:
  - R-type 0110011: funct3/funct7 000/0000000 add; 000/0100000 sub; 001/0000000 sll; 100/0000000 xor; 101/0000000 srl; 101/0100000 sra; 111/0000000 and. a=rs1, b=rs2; reg_write=1.
  - I-ALU 0010011: funct3 000 addi, 100 xori, 111 andi, b = sign-extended instr[31:20]. funct3 001 slli (funct7=0), 101 srli/srai (instr[30]). reg_write=1.
  - Load 0000011: add, b = I-imm, mem_read=1, reg_write=1.
  - Store 0100011: add, b = sign-extended {instr[31:25],instr[11:7]}, mem_write=1, store_data=rs2.
  - Branch 1100011: funct3 000 beq, 001 bne; sub, a=rs1, b=rs2, branch=1.
- Shift operand rule: for every shift (R or I), b = {27'b0, shamt[4:0]}, with shamt taken from rs2[4:0] or instr[24:20]. The ALU shifts by full b, so upper bits must be zero.
- Anything else (or/slt/sltu/lui/jal/other funct) sets illegal=1, alu_control=000, and reg_write/mem_read/mem_write/branch=0.
- x0: rs index 0 reads 0, ignoring in_rsN_data and forwarding. rd=0 forces reg_write=0.
- Forwarding: if fwd_valid and fwd_rd!=0 and fwd_rd==rs1 (rs2), use fwd_data for rs1 (rs2). This applies to a, b and store_data. Forwarding is combinational at capture.
- Handshake: in_ready = !out_valid || out_ready. A transfer occurs when in_valid && in_ready. Capture happens at the clock edge; latency is 1 cycle from accepted input to out_valid.
- Stall: out_valid && !out_ready keeps all out_* stable, and in_ready=0.
- Drain: out_ready && !(in_valid && in_ready) clears out_valid next cycle.
- Flush: takes priority over everything. Next cycle out_valid=0, any same-cycle input is dropped, in_ready is unaffected.
- Reset: takes priority over flush. All out_* are 0 (alu_control=000, illegal=0) and out_valid=0. in_ready=1 the cycle after reset deasserts. Reset mid-stall discards the held instruction.
- Payload registers update only on transfer. Data outputs hold their last value when out_valid=0.

Test Plan:
- Reset then R-type add x3,x1,x2 with rs1=5, rs2=7 -> next cycle out_valid=1, a=5, b=7, ctrl=000, rd=3, reg_write=1.
- srai x4,x1,3 (instr 0x4030D213) with rs1=0x80000000 -> ctrl=010, b=3. R-type sll with rs2=0xFFFFFF21 -> ctrl=011, b=1.
- sw x2,-4(x1) with rs1=0x100, rs2=0xAB -> ctrl=000, b=0xFFFFFFFC, mem_write=1, store_data=0xAB, reg_write=0.
- Forwarding: fwd_valid=1, fwd_rd=1, fwd_data=0x55 on bne x1,x2 -> a=0x55, ctrl=001, branch_ne=1. Same with fwd_rd=0 and rs=x0 -> a=0.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged. Raise out_ready -> next instruction appears after 1 cycle.
- flush asserted with in_valid=1 while stalled -> next cycle out_valid=0. An or x1,x2,x3 instruction -> illegal=1, reg_write=0.
